// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: instruction-type codes, reset PC and the
// instruction-memory window used by the optional fetch-address check
// (enabled with the FETCH_ALIGN_CHECK_EN macro in fetch_unit).
package fetch_unit_pkg;

  // Decoded instruction-type codes carried on D_inStrType
  localparam logic [9:0] TYPE_OTHER = 10'd0;
  localparam logic [9:0] TYPE_BEQ   = 10'd1;
  localparam logic [9:0] TYPE_BNE   = 10'd2;
  localparam logic [9:0] TYPE_BSLT  = 10'd3;
  localparam logic [9:0] TYPE_J     = 10'd4;
  localparam logic [9:0] TYPE_JAL   = 10'd5;
  localparam logic [9:0] TYPE_JR    = 10'd6;

  // Address map
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFC;

  // Source chosen for the next fetch address
  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JR     = 2'd3
  } npc_sel_e;

  // True for the conditional-branch types
  function automatic logic is_branch_type(input logic [9:0] t);
    return (t == TYPE_BEQ) || (t == TYPE_BNE) || (t == TYPE_BSLT);
  endfunction

endpackage

// File: rtl/fetch_unit_npc.sv
// Next-PC selection for the fetch stage. Purely combinational; priority is
// conditional branch, then j/jal, then jr, then sequential F_PC+4.
// Branch and jump targets are relative to the instruction in D, the
// sequential address is relative to F (delay-slot architecture).
module npc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] f_pc,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_instr_index,
  input  logic [31:0] d_rd1,
  input  logic [9:0]  d_instr_type,
  input  logic        d_is_branch,
  output logic [31:0] next_pc
);

  logic [31:0] f_pc4;
  logic [31:0] d_pc4;
  logic [31:0] branch_off;
  npc_sel_e    sel;

  // Pick the redirect source and form the next fetch address (mod 2^32)
  always_comb begin
    f_pc4      = f_pc + 32'd4;
    d_pc4      = d_pc + 32'd4;
    branch_off = {{14{d_imm16[15]}}, d_imm16, 2'b00};
    sel        = NPC_SEQ;
    if (is_branch_type(d_instr_type)) begin
      sel = d_is_branch ? NPC_BRANCH : NPC_SEQ;
    end else if ((d_instr_type == TYPE_J) || (d_instr_type == TYPE_JAL)) begin
      sel = NPC_JUMP;
    end else if (d_instr_type == TYPE_JR) begin
      sel = NPC_JR;
    end
    case (sel)
      NPC_BRANCH: next_pc = d_pc4 + branch_off;
      NPC_JUMP:   next_pc = {d_pc4[31:28], d_instr_index, 2'b00};
      NPC_JR:     next_pc = d_rd1;
      default:    next_pc = f_pc4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, F/D pipeline register and next-PC selection.
// There is no valid/ready handshake: stall=1 freezes PC and F/D, otherwise
// every edge advances. Redirects take effect one cycle after being decided
// and the delay-slot instruction always enters D (no flush).
// Optional feature: define FETCH_ALIGN_CHECK_EN to flag misaligned or
// out-of-window fetch addresses and replace the fetched word with a nop.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] F_instr,
  input  logic        D_isBranch,
  input  logic [9:0]  D_inStrType,
  input  logic [31:0] D_RD1,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic [31:0] D_PC8,
  output logic        F_excAdEL,
  output logic        D_excAdEL
);

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] next_pc;
  logic        f_exc;

  npc u_npc (
    .f_pc          (f_pc_q),
    .d_pc          (d_pc_q),
    .d_imm16       (d_instr_q[15:0]),
    .d_instr_index (d_instr_q[25:0]),
    .d_rd1         (D_RD1),
    .d_instr_type  (D_inStrType),
    .d_is_branch   (D_isBranch),
    .next_pc       (next_pc)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic d_exc_q, d_exc_d;

  assign f_exc = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IM_LO) || (f_pc_q > IM_HI);
`else
  assign f_exc = 1'b0;
`endif

  // Next-state for PC and F/D: hold on stall, otherwise advance
  always_comb begin
    f_pc_d    = f_pc_q;
    d_pc_d    = d_pc_q;
    d_instr_d = d_instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    d_exc_d   = d_exc_q;
`endif
    if (!stall) begin
      f_pc_d = next_pc;
      d_pc_d = f_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
      d_instr_d = f_exc ? 32'h0000_0000 : F_instr;
      d_exc_d   = f_exc;
`else
      d_instr_d = F_instr;
`endif
    end
  end

  // Pipeline registers; reset wins over stall and any pending redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q    <= PC_RESET;
      d_pc_q    <= PC_RESET;
      d_instr_q <= 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
      d_exc_q   <= 1'b0;
`endif
    end else begin
      f_pc_q    <= f_pc_d;
      d_pc_q    <= d_pc_d;
      d_instr_q <= d_instr_d;
`ifdef FETCH_ALIGN_CHECK_EN
      d_exc_q   <= d_exc_d;
`endif
    end
  end

  assign F_PC      = f_pc_q;
  assign D_PC      = d_pc_q;
  assign D_instr   = d_instr_q;
  assign D_PC8     = d_pc_q + 32'd8;
  assign F_excAdEL = f_exc;
`ifdef FETCH_ALIGN_CHECK_EN
  assign D_excAdEL = d_exc_q;
`else
  assign D_excAdEL = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, untaken bslt, taken beq with delay
// slot, jr under stall, j and j-with-reset, address wrap, alignment flags.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] F_instr;
  logic        D_isBranch;
  logic [9:0]  D_inStrType;
  logic [31:0] D_RD1;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic [31:0] D_PC8;
  logic        F_excAdEL;
  logic        D_excAdEL;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .F_instr     (F_instr),
    .D_isBranch  (D_isBranch),
    .D_inStrType (D_inStrType),
    .D_RD1       (D_RD1),
    .F_PC        (F_PC),
    .D_PC        (D_PC),
    .D_instr     (D_instr),
    .D_PC8       (D_PC8),
    .F_excAdEL   (F_excAdEL),
    .D_excAdEL   (D_excAdEL)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic rst, input logic stl, input logic [31:0] instr,
                       input logic [9:0] typ, input logic br, input logic [31:0] rd1);
    reset       = rst;
    stall       = stl;
    F_instr     = instr;
    D_inStrType = typ;
    D_isBranch  = br;
    D_RD1       = rd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic expect_state(input logic [31:0] f, input logic [31:0] dpc,
                              input logic [31:0] dinstr);
    push(f);
    push(dpc);
    push(dinstr);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".F_PC"}, F_PC);
    check({tag, ".D_PC"}, D_PC);
    check({tag, ".D_instr"}, D_instr);
  endtask

  initial begin
    // Reset held two cycles
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, TYPE_OTHER, 1'b0, 32'h0);
    tick();
    expect_state(32'h3000, 32'h3000, 32'h0);
    tick();
    check_state("reset");
    push(32'h3008); check("reset.D_PC8", D_PC8);
    push(32'h0);    check("reset.F_excAdEL", {31'd0, F_excAdEL});
    push(32'h0);    check("reset.D_excAdEL", {31'd0, D_excAdEL});

    // Release: sequential fetch
    drive(1'b0, 1'b0, 32'h1111_1111, TYPE_OTHER, 1'b0, 32'h0);
    expect_state(32'h3004, 32'h3000, 32'h1111_1111);
    tick(); check_state("rel1");
    drive(1'b0, 1'b0, 32'h2222_2222, TYPE_OTHER, 1'b0, 32'h0);
    expect_state(32'h3008, 32'h3004, 32'h2222_2222);
    tick(); check_state("rel2");

    // Untaken bslt keeps sequential flow
    drive(1'b0, 1'b0, 32'h0C00_0003, TYPE_BSLT, 1'b0, 32'h0);
    push(32'h300C); tick(); check("bslt_nt1.F_PC", F_PC);
    drive(1'b0, 1'b0, 32'h0C00_0004, TYPE_BSLT, 1'b0, 32'h0);
    push(32'h3010); tick(); check("bslt_nt2.F_PC", F_PC);

    // Taken beq at 0x3008, imm16=0xFFFE
    drive(1'b1, 1'b0, 32'h0, TYPE_OTHER, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h1111_1111, TYPE_OTHER, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h2222_2222, TYPE_OTHER, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h1000_FFFE, TYPE_OTHER, 1'b0, 32'h0);
    expect_state(32'h300C, 32'h3008, 32'h1000_FFFE);
    tick(); check_state("beq_load");
    push(32'h3010); check("beq_load.D_PC8", D_PC8);
    drive(1'b0, 1'b0, 32'h3333_3333, TYPE_BEQ, 1'b1, 32'h0);
    expect_state(32'h3004, 32'h300C, 32'h3333_3333);
    tick(); check_state("beq_taken");

    // jr in D under a two-cycle stall
    drive(1'b0, 1'b1, 32'h5555_5555, TYPE_JR, 1'b0, 32'h3400);
    expect_state(32'h3004, 32'h300C, 32'h3333_3333);
    tick(); check_state("jr_stall1");
    expect_state(32'h3004, 32'h300C, 32'h3333_3333);
    tick(); check_state("jr_stall2");
    drive(1'b0, 1'b0, 32'h5555_5555, TYPE_JR, 1'b0, 32'h3400);
    expect_state(32'h3400, 32'h3004, 32'h5555_5555);
    tick(); check_state("jr_release");

    // j with index 0x0000C10
    drive(1'b0, 1'b0, 32'h0800_0C10, TYPE_OTHER, 1'b0, 32'h0);
    expect_state(32'h3404, 32'h3400, 32'h0800_0C10);
    tick(); check_state("j_load");
    drive(1'b0, 1'b0, 32'h6666_0000, TYPE_J, 1'b0, 32'h0);
    expect_state(32'h3040, 32'h3404, 32'h6666_0000);
    tick(); check_state("j_taken");

    // Same j, but reset asserted in the redirect cycle
    drive(1'b0, 1'b0, 32'h0800_0C10, TYPE_OTHER, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h6666_0001, TYPE_J, 1'b0, 32'h0);
    expect_state(32'h3000, 32'h3000, 32'h0);
    tick(); check_state("j_reset");
    drive(1'b0, 1'b0, 32'h6666_0002, TYPE_OTHER, 1'b0, 32'h0);
    push(32'h3004); tick(); check("j_reset_rel.F_PC", F_PC);

    // Address wrap at 0xFFFF_FFFC
    drive(1'b0, 1'b0, 32'h7777_0000, TYPE_JR, 1'b0, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC); tick(); check("wrap_jr.F_PC", F_PC);
    push({31'd0, ALIGN_EN}); check("wrap_jr.F_excAdEL", {31'd0, F_excAdEL});
    drive(1'b0, 1'b0, 32'h7777_7777, TYPE_OTHER, 1'b0, 32'h0);
    expect_state(32'h0, 32'hFFFF_FFFC, ALIGN_EN ? 32'h0 : 32'h7777_7777);
    tick(); check_state("wrap");
    push(32'h0000_0004); check("wrap.D_PC8", D_PC8);
    push({31'd0, ALIGN_EN}); check("wrap.D_excAdEL", {31'd0, D_excAdEL});

    // Misaligned jr target 0x3002
    drive(1'b1, 1'b0, 32'h0, TYPE_OTHER, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h1111_1111, TYPE_JR, 1'b0, 32'h3002);
    push(32'h3002); tick(); check("align_jr.F_PC", F_PC);
    push({31'd0, ALIGN_EN}); check("align_jr.F_excAdEL", {31'd0, F_excAdEL});
    push(32'h0); check("align_jr.D_excAdEL", {31'd0, D_excAdEL});
    drive(1'b0, 1'b0, 32'h6666_6666, TYPE_OTHER, 1'b0, 32'h0);
    expect_state(32'h3006, 32'h3002, ALIGN_EN ? 32'h0 : 32'h6666_6666);
    tick(); check_state("align_cap");
    push({31'd0, ALIGN_EN}); check("align_cap.D_excAdEL", {31'd0, D_excAdEL});

    // Back in range: exception flag clears on the next capture
    drive(1'b0, 1'b0, 32'h8888_8888, TYPE_JR, 1'b0, 32'h3100);
    push(32'h3100); tick(); check("align_back.F_PC", F_PC);
    push(32'h0); check("align_back.F_excAdEL", {31'd0, F_excAdEL});
    drive(1'b0, 1'b0, 32'h9999_9999, TYPE_OTHER, 1'b0, 32'h0);
    expect_state(32'h3104, 32'h3100, 32'h9999_9999);
    tick(); check_state("align_clear");
    push(32'h0); check("align_clear.D_excAdEL", {31'd0, D_excAdEL});

    // Report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single pipeline clock; every register updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port stall, input, 1 bit: hazard-unit freeze of the PC and the F/D register.
REQ-004 SHALL have port F_instr, input, 32 bits: instruction word returned by IM for the current F_PC.
REQ-005 SHALL have port D_isBranch, input, 1 bit: branch-taken flag produced by the comparator for the instruction in D.
REQ-006 SHALL have port D_inStrType, input, 10 bits: decoded instruction-type code of the instruction in D.
REQ-007 SHALL have port D_RD1, input, 32 bits: forwarded rs value, used as the jr target.
REQ-008 SHALL have port F_PC, output, 32 bits: fetch address driven to IM.
REQ-009 SHALL have ports D_PC and D_instr, output, 32 bits each: registered PC and instruction of the D stage.
REQ-010 SHALL have port D_PC8, output, 32 bits: D_PC+8, the link value for jal.
REQ-011 SHALL have ports F_excAdEL and D_excAdEL, output, 1 bit each: fetch-address exception flags.

Function
REQ-012 SHALL decode D_imm16 = D_instr[15:0] and D_instrIndex = D_instr[25:0] internally, with no additional ports.
REQ-013 SHALL compute the next PC with priority beq/bne/bslt, then j/jal, then jr, then sequential.
REQ-014 SHALL take the branch target D_PC+4+(sign-extended D_imm16 shifted left 2) when D_inStrType is a branch type and D_isBranch=1.
REQ-015 SHALL use the sequential address F_PC+4 when D_inStrType is a branch type and D_isBranch=0.
REQ-016 SHALL take {D_PC+4 bits[31:28], D_instrIndex, 2'b00} for j and jal.
REQ-017 SHALL take D_RD1 unmodified for jr.
REQ-018 SHALL take F_PC+4 for all other instruction types.
REQ-019 SHALL perform all address arithmetic modulo 2^32, so that 0xFFFF_FFFC+4 wraps to 0x0000_0000.
REQ-020 SHALL implement branch delay-slot semantics: the instruction fetched in the cycle a redirect is decided always enters D, and no flush exists.
REQ-021 SHALL, when stall=1, hold F_PC, D_PC and D_instr; a redirect decided during a stall takes effect in the first cycle with stall=0 because the D inputs are also held.
REQ-022 SHALL, when stall=0, load F_PC with the next PC and load D_PC/D_instr with F_PC/F_instr each cycle.
REQ-023 SHALL provide a redirect latency of exactly one cycle: redirect decided in cycle N produces the new F_PC in cycle N+1.
REQ-024 SHALL drive D_PC8 combinationally as D_PC+8, wrapping modulo 2^32.

Reset
REQ-025 SHALL, when reset=1 at a clock edge, set F_PC=0x0000_3000, D_PC=0x0000_3000, D_instr=0x0000_0000 (nop) and D_excAdEL=0.
REQ-026 SHALL give reset priority over stall and over any redirect.
REQ-027 SHALL abandon a pending redirect when reset is asserted mid-operation.

Configuration
REQ-028 SHALL, when FETCH_ALIGN_CHECK_EN is defined, assert F_excAdEL combinationally when F_PC[1:0]!=0 or F_PC lies outside 0x0000_3000..0x0000_6FFC.
REQ-029 SHALL, under FETCH_ALIGN_CHECK_EN, load D_instr with 0x0000_0000 and register D_excAdEL=1 on a non-stalled edge while F_excAdEL=1.
REQ-030 SHALL, when FETCH_ALIGN_CHECK_EN is not defined, tie both exception ports to 0 and capture F_instr unconditionally.

Structure
REQ-031 SHALL place the type codes (beq, bne, bslt, j, jal, jr), PC_RESET=0x0000_3000, IM_LO=0x0000_3000 and IM_HI=0x0000_6FFC in the shared definitions header included by all stages.
REQ-032 SHALL implement the next-PC selection as a combinational sub-module npc and keep all registers in fetch_unit.

Verification
REQ-033 SHALL include a reset scenario: reset held 2 cycles, then released -> F_PC=0x3000, D_instr=0, and F_PC=0x3004 one cycle after release.
REQ-034 SHALL include a taken-beq scenario: beq at 0x3008 with imm16=0xFFFE and D_isBranch=1 -> delay slot 0x300C enters D, then F_PC=0x3004.
REQ-035 SHALL include an untaken-bslt scenario: D_isBranch=0 -> F_PC advances sequentially 0x300C, 0x3010.
REQ-036 SHALL include a jr-under-stall scenario: jr in D with D_RD1=0x3400 and stall=1 for 2 cycles -> F_PC, D_PC, D_instr held, and F_PC=0x3400 one cycle after stall drops.
REQ-037 SHALL include a j-plus-reset scenario: j with index 0x0000C10 -> F_PC=0x0000_3040; reset asserted in the same cycle instead -> F_PC=0x3000.
REQ-038 SHALL include an alignment scenario under FETCH_ALIGN_CHECK_EN: jr to 0x3002 -> F_excAdEL=1, next D_instr=0 with D_excAdEL=1; without the macro both flags stay 0.
